mem_sweep_ctrl: RTL and testbench
=================================

MEM_SWEEP_CTRL -- requirements
Module: mem_sweep_ctrl

Interface
REQ-001 Parameter WID_MEM, default 4, data word width of the attached memory.
REQ-002 Parameter DEPTH_MEM, default 8192, number of words swept; power of two, 16 to 8192.
REQ-003 Parameter ADDR_W, default 13, memory address width; 2**ADDR_W >= DEPTH_MEM.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-007 do_write  in  1  sampled with start; 1 = fill memory with pattern before the read sweep.
REQ-008 check_en  in  1  sampled with start; 1 = compare readback against pattern.
REQ-009 seed  in  WID_MEM  pattern seed, sampled with start.
REQ-010 raddr  out  ADDR_W  memory read address; memory returns ram[raddr] one cycle later.
REQ-011 waddr  out  ADDR_W  memory write address; the memory writes din to waddr on every clock edge.
REQ-012 din  out  WID_MEM  memory write data.
REQ-013 mem_dout  in  WID_MEM  registered memory read data.
REQ-014 busy  out  1  high in WRITE, READ and DRAIN.
REQ-015 done  out  1  one-cycle pulse at sweep completion.
REQ-016 err_cnt  out  ADDR_W+1  count of mismatching words, saturating at all-ones.
REQ-017 first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
REQ-018 checksum  out  16  rolling checksum of all read data.

Function
REQ-019 States are IDLE, WRITE, READ and DRAIN; IDLE -> WRITE on start with do_write=1; IDLE -> READ on start with do_write=0; WRITE -> READ after address DEPTH_MEM-1; READ -> DRAIN after address DEPTH_MEM-1 is issued; DRAIN -> IDLE after one cycle.
REQ-020 pattern(a) = a[WID_MEM-1:0] XOR seed_q, where a is zero-extended when WID_MEM > ADDR_W.
REQ-021 WRITE phase: waddr steps 0..DEPTH_MEM-1, one address per cycle; din = pattern(waddr); raddr = waddr.
REQ-022 The memory has no write enable, so outside WRITE the block drives write-back: waddr = raddr of the previous cycle and din = mem_dout. This rewrites the word just read, unchanged.
REQ-023 READ phase: raddr steps 0..DEPTH_MEM-1, one address per cycle; the data for address k is consumed the cycle after it is issued (in READ for k<DEPTH_MEM-1, in DRAIN for the last word).
REQ-024 Each consumed word d updates checksum = {checksum[14:0], checksum[15]} XOR zero_extend(d).
REQ-025 With check_en_q=1, a consumed word d is a mismatch when d != pattern(k); err_cnt increments, saturating; first_err_addr is loaded on the first mismatch only.
REQ-026 At sweep start (leaving IDLE), checksum, err_cnt and first_err_addr clear to 0; they hold their values in IDLE after done.
REQ-027 done pulses on the DRAIN -> IDLE transition cycle; checksum and err results are final and stable when done is high.
REQ-028 Sweep latency from start: DEPTH_MEM+2 cycles without write; 2*DEPTH_MEM+2 cycles with write.
REQ-029 In IDLE, raddr holds its last value; waddr and din follow REQ-022.
REQ-030 start while busy is ignored; a start coincident with done is ignored.
REQ-031 Address counters do not wrap: the last address issued is DEPTH_MEM-1, then the state advances.

Reset
REQ-032 While reset is high: state = IDLE, raddr = waddr = 0, busy = done = 0, err_cnt = first_err_addr = checksum = 0, and all sampled config bits = 0.
REQ-033 Reset mid-sweep aborts immediately and done is not pulsed. The block does not restore memory contents; address 0 may receive mem_dout during reset, and memory content is re-established by bitstream reinit.

Verification (DEPTH_MEM=16, WID_MEM=4, ADDR_W=4, behavioural read-first memory model)
REQ-034 start, do_write=1, check_en=1, seed=4'h5 -> memory[a] = a^5 for all a; done at cycle 34; err_cnt=0; checksum matches the model.
REQ-035 After REQ-034, force memory[9] = 4'h0, then start with do_write=0, check_en=1, seed=5 -> done at cycle 18; err_cnt=1; first_err_addr=9.
REQ-036 Read-only sweep, check_en=0 -> err_cnt=0; memory contents unchanged word for word (write-back check).
REQ-037 Assert reset at cycle 7 of a write sweep -> outputs return to the REQ-032 values asynchronously; no done pulse; a new start completes normally.
REQ-038 start pulsed again mid-sweep and on the done cycle -> ignored; exactly one done pulse per accepted start.
REQ-039 All 16 words mismatching with ADDR_W=4 -> err_cnt=16 (no saturation); force err_cnt to all-ones -> it holds at all-ones.

Source files
------------

// File: rtl/mem_sweep_ctrl.sv
// Memory sweep controller: optional pattern fill, full read sweep with checksum and
// mismatch counting, and write-back of each word read on a memory that has no write enable.
module mem_sweep_ctrl #(
  parameter int WID_MEM   = 4,
  parameter int DEPTH_MEM = 8192,
  parameter int ADDR_W    = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                do_write,
  input  logic                check_en,
  input  logic [WID_MEM-1:0]  seed,
  output logic [ADDR_W-1:0]   raddr,
  output logic [ADDR_W-1:0]   waddr,
  output logic [WID_MEM-1:0]  din,
  input  logic [WID_MEM-1:0]  mem_dout,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     err_cnt,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [15:0]         checksum
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W:0]   ERR_MAX   = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   prev_addr_q;
  logic                wr_last_q;
  logic                rd_valid_q;
  logic                done_q, done_d;
  logic                check_en_q, check_en_d;
  logic [WID_MEM-1:0]  seed_q, seed_d;
  logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic [15:0]         checksum_q, checksum_d;

  function automatic logic [WID_MEM-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [WID_MEM-1:0] s);
    return WID_MEM'(a) ^ s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      prev_addr_q <= '0;
      wr_last_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      check_en_q  <= 1'b0;
      seed_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prev_addr_q <= addr_q;
      wr_last_q   <= (state_q == WRITE);
      rd_valid_q  <= (state_q == READ);
      done_q      <= done_d;
      check_en_q  <= check_en_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    check_en_d  = check_en_q;
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    checksum_d  = checksum_q;

    // Read data lags its address by one cycle; prev_addr_q names the word now on mem_dout.
    if (rd_valid_q) begin
      checksum_d = {checksum_q[14:0], checksum_q[15]} ^ 16'(mem_dout);
      if (check_en_q && (mem_dout != pattern(prev_addr_q, seed_q))) begin
        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_q == '0) first_err_d = prev_addr_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d     = do_write ? WRITE : READ;
          addr_d      = '0;
          check_en_d  = check_en;
          seed_d      = seed;
          err_cnt_d   = '0;
          first_err_d = '0;
          checksum_d  = '0;
        end
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) state_d = DRAIN;
        else addr_d = addr_q + 1'b1;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The cycle after WRITE, mem_dout still holds the pre-fill value of the last word,
  // so the pattern is rewritten instead of the stale read data.
  always_comb begin
    raddr = addr_q;
    if (state_q == WRITE) begin
      waddr = addr_q;
      din   = pattern(addr_q, seed_q);
    end else begin
      waddr = prev_addr_q;
      din   = wr_last_q ? pattern(prev_addr_q, seed_q) : mem_dout;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Self-checking bench for mem_sweep_ctrl with a 16x4 read-first memory model;
// a vector table drives whole sweeps, hand-written sequences cover reset, ignored starts and saturation.
module tb_mem_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        do_write;
  logic        check_en;
  logic [3:0]  seed;
  logic [3:0]  raddr;
  logic [3:0]  waddr;
  logic [3:0]  din;
  logic [3:0]  mem_dout;
  logic        busy;
  logic        done;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_addr;
  logic [15:0] checksum;

  logic [3:0]  mem [16];
  logic [3:0]  ref_mem [16];
  logic        poke_en;
  logic [3:0]  poke_addr;
  logic [3:0]  poke_data;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct {
    logic       dw;
    logic       ce;
    logic [3:0] sd;
    logic       poke;
    logic [3:0] paddr;
    logic [3:0] pdata;
    int         lat;
    int         err;
    int         first;
  } vec_t;

  vec_t vecs [6];

  mem_sweep_ctrl #(.WID_MEM(4), .DEPTH_MEM(16), .ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .do_write       (do_write),
    .check_en       (check_en),
    .seed           (seed),
    .raddr          (raddr),
    .waddr          (waddr),
    .din            (din),
    .mem_dout       (mem_dout),
    .busy           (busy),
    .done           (done),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  // Read-first memory: the read sees the value from before this edge's write.
  always @(posedge clk) begin
    mem_dout <= mem[raddr];
    mem[waddr] <= din;
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] model_checksum();
    logic [15:0] cs = 16'h0;
    for (int a = 0; a < 16; a++) cs = {cs[14:0], cs[15]} ^ {12'h0, ref_mem[a]};
    return cs;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int a = 0; a < 16; a++) if (mem[a] !== ref_mem[a]) n++;
    return n;
  endfunction

  task automatic applyStimulus(input logic dw, input logic ce, input logic [3:0] sd,
                               output int lat);
    @(negedge clk);
    start = 1'b1; do_write = dw; check_en = ce; seed = sd;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0; do_write = 1'b0; check_en = 1'b0; seed = 4'h0;
        checkOutput("busy_after_start", int'(busy), 1);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
    if (dw) for (int a = 0; a < 16; a++) ref_mem[a] = 4'(a) ^ sd;
  endtask

  initial begin
    int lat;
    int d0;
    logic [15:0] cs_hold;

    vecs[0] = '{dw:1'b1, ce:1'b1, sd:4'h5, poke:1'b0, paddr:4'h0, pdata:4'h0, lat:34, err:0,  first:0};
    vecs[1] = '{dw:1'b0, ce:1'b1, sd:4'h5, poke:1'b1, paddr:4'h9, pdata:4'h0, lat:18, err:1,  first:9};
    vecs[2] = '{dw:1'b0, ce:1'b0, sd:4'h5, poke:1'b0, paddr:4'h0, pdata:4'h0, lat:18, err:0,  first:0};
    vecs[3] = '{dw:1'b1, ce:1'b1, sd:4'hA, poke:1'b0, paddr:4'h0, pdata:4'h0, lat:34, err:0,  first:0};
    vecs[4] = '{dw:1'b0, ce:1'b1, sd:4'h5, poke:1'b0, paddr:4'h0, pdata:4'h0, lat:18, err:16, first:0};
    vecs[5] = '{dw:1'b0, ce:1'b1, sd:4'hA, poke:1'b1, paddr:4'h3, pdata:4'h0, lat:18, err:1,  first:3};

    reset = 1'b1; start = 1'b0; do_write = 1'b0; check_en = 1'b0; seed = 4'h0;
    poke_en = 1'b0; poke_addr = 4'h0; poke_data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_raddr", int'(raddr), 0);
    checkOutput("rst_waddr", int'(waddr), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err_cnt", int'(err_cnt), 0);
    checkOutput("rst_first_err", int'(first_err_addr), 0);
    checkOutput("rst_checksum", int'(checksum), 0);
    @(negedge clk) reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].poke) begin
        @(negedge clk);
        poke_en = 1'b1; poke_addr = vecs[v].paddr; poke_data = vecs[v].pdata;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[vecs[v].paddr] = vecs[v].pdata;
      end
      applyStimulus(vecs[v].dw, vecs[v].ce, vecs[v].sd, lat);
      checkOutput($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      checkOutput($sformatf("v%0d_err_cnt", v), int'(err_cnt), vecs[v].err);
      checkOutput($sformatf("v%0d_first_err", v), int'(first_err_addr), vecs[v].first);
      checkOutput($sformatf("v%0d_checksum", v), int'(checksum), int'(model_checksum()));
      cs_hold = model_checksum();
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_done_one_cycle", v), int'(done), 0);
      checkOutput($sformatf("v%0d_checksum_hold", v), int'(checksum), int'(cs_hold));
      checkOutput($sformatf("v%0d_mem_diffs", v), mem_diffs(), 0);
    end

    // Reset asserted in cycle 7 of a write sweep must abort without a done pulse.
    @(negedge clk);
    start = 1'b1; do_write = 1'b1; check_en = 1'b1; seed = 4'h3;
    @(posedge clk); #1;
    start = 1'b0; do_write = 1'b0; check_en = 1'b0; seed = 4'h0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_raddr", int'(raddr), 0);
    checkOutput("abort_waddr", int'(waddr), 0);
    checkOutput("abort_err_cnt", int'(err_cnt), 0);
    checkOutput("abort_checksum", int'(checksum), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_idle", int'(busy), 0);

    applyStimulus(1'b1, 1'b1, 4'h5, lat);
    checkOutput("recover_latency", lat, 34);
    checkOutput("recover_err_cnt", int'(err_cnt), 0);
    checkOutput("recover_checksum", int'(checksum), int'(model_checksum()));
    @(posedge clk); #1;
    checkOutput("recover_mem_diffs", mem_diffs(), 0);

    // Starts mid-sweep and on the done cycle are both ignored.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; do_write = 1'b0; check_en = 1'b1; seed = 4'h5;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      start = (n == 5); do_write = (n == 5); seed = (n == 5) ? 4'hA : 4'h5;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) checkOutput("ignore_done_timeout", 0, 1);
    checkOutput("ignore_latency", lat, 18);
    checkOutput("ignore_err_cnt", int'(err_cnt), 0);
    start = 1'b1; do_write = 1'b1; seed = 4'hA;
    @(posedge clk); #1;
    start = 1'b0; do_write = 1'b0; check_en = 1'b0; seed = 4'h0;
    checkOutput("ignore_start_on_done", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ignore_single_done", done_cnt - d0, 1);
    checkOutput("ignore_mem_diffs", mem_diffs(), 0);

    // All words mismatch; a forced all-ones count must hold rather than wrap.
    @(negedge clk);
    start = 1'b1; do_write = 1'b0; check_en = 1'b1; seed = 4'hA;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0; check_en = 1'b0; seed = 4'h0;
      end
      if (n == 5) force dut.err_cnt_q = 5'h1f;
      if (n == 6) release dut.err_cnt_q;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) checkOutput("sat_done_timeout", 0, 1);
    checkOutput("sat_latency", lat, 18);
    checkOutput("sat_err_cnt", int'(err_cnt), 31);
    checkOutput("sat_first_err", int'(first_err_addr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
